dmem_responder: RTL and testbench



---
 rtl/dmem_responder.sv | 220 ++++++++++++++++++++++
 tb/tb_dmem_responder.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Handshaked RV32I data-memory target with programmable access latency.
// Optional fault detection is enabled by defining DMEM_FAULT_CHECK_EN.
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        ReqValid,
    output logic        ReqReady,
    input  logic        ReqWrite,
    input  logic [31:0] ReqAddr,
    input  logic [2:0]  ReqFunct3,
    input  logic [31:0] ReqWData,
    output logic        RspValid,
    input  logic        RspReady,
    output logic [31:0] RspRData,
    output logic        RspErr
);

    localparam int         IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_RESP  = 2'd2;
    localparam logic [3:0] CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;
    localparam bit         ZERO_LAT = (LATENCY == 0);

    logic [1:0]  state_r;
    logic [1:0]  state_nxt_s;
    logic [3:0]  cnt_r;
    logic        wr_r;
    logic [31:0] addr_r;
    logic [2:0]  f3_r;
    logic [31:0] wdata_r;
    logic        ready_r;
    logic        valid_r;
    logic [31:0] rdata_r;
    logic        err_r;

    logic        accept_s;
    logic        access_s;
    logic        acc_wr_s;
    logic [31:0] acc_addr_s;
    logic [2:0]  acc_f3_s;
    logic [31:0] acc_wdata_s;
    logic        err_s;
    logic [IDX_W-1:0] idx_s;
    logic [31:0] word_s;
    logic [31:0] merged_s;
    logic        mem_we_s;

    logic [31:0] mem_r [DEPTH_WORDS];

    // Select the lane addressed by the request and extend it to 32 bits.
    function automatic logic [31:0] load_extract(input logic [31:0] word,
                                                 input logic [1:0]  lane,
                                                 input logic [2:0]  f3);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = lane[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  r = {{24{b[7]}}, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b100:  r = {24'd0, b};
            3'b101:  r = {16'd0, h};
            default: r = word;
        endcase
        return r;
    endfunction

    // Byte-lane merge of store data into the existing word; anything that is
    // not SB/SH writes the full word.
    function automatic logic [31:0] store_merge(input logic [31:0] word,
                                                input logic [31:0] wdata,
                                                input logic [1:0]  lane,
                                                input logic [2:0]  f3);
        logic [31:0] r;
        r = word;
        case (f3)
            3'b000: begin
                case (lane)
                    2'd0:    r[7:0]   = wdata[7:0];
                    2'd1:    r[15:8]  = wdata[7:0];
                    2'd2:    r[23:16] = wdata[7:0];
                    default: r[31:24] = wdata[7:0];
                endcase
            end
            3'b001: begin
                if (lane[1]) r[31:16] = wdata[15:0];
                else         r[15:0]  = wdata[15:0];
            end
            default: r = wdata;
        endcase
        return r;
    endfunction

    assign accept_s = (state_r == ST_IDLE) && ReqValid && ready_r;
    assign access_s = ((state_r == ST_WAIT) && (cnt_r == 4'd0)) || (ZERO_LAT && accept_s);

    // With zero latency the access happens on the accepting edge, so use the live request.
    always_comb begin
        acc_wr_s    = wr_r;
        acc_addr_s  = addr_r;
        acc_f3_s    = f3_r;
        acc_wdata_s = wdata_r;
        if (ZERO_LAT) begin
            acc_wr_s    = ReqWrite;
            acc_addr_s  = ReqAddr;
            acc_f3_s    = ReqFunct3;
            acc_wdata_s = ReqWData;
        end else begin
            acc_wr_s    = wr_r;
            acc_addr_s  = addr_r;
            acc_f3_s    = f3_r;
            acc_wdata_s = wdata_r;
        end
    end

`ifdef DMEM_FAULT_CHECK_EN
    logic supported_s;
    logic misalign_s;
    logic oob_s;

    // Fault classification: unsupported funct3, misalignment, out-of-range index.
    always_comb begin
        supported_s = 1'b0;
        if (acc_wr_s) begin
            supported_s = (acc_f3_s <= 3'b010);
        end else begin
            supported_s = (acc_f3_s != 3'b011) && (acc_f3_s != 3'b110) && (acc_f3_s != 3'b111);
        end
        misalign_s = ((acc_f3_s[1:0] == 2'b01) && acc_addr_s[0]) ||
                     ((acc_f3_s[1:0] == 2'b10) && (acc_addr_s[1:0] != 2'b00));
        oob_s      = ({2'b00, acc_addr_s[31:2]} >= 32'(DEPTH_WORDS));
        err_s      = !supported_s || misalign_s || oob_s;
    end
`else
    assign err_s = 1'b0;
`endif

    // Out-of-range indices only reach the array when faults are not checked: they wrap.
    assign idx_s    = IDX_W'({2'b00, acc_addr_s[31:2]} % 32'(DEPTH_WORDS));
    assign word_s   = mem_r[idx_s];
    assign merged_s = store_merge(word_s, acc_wdata_s, acc_addr_s[1:0], acc_f3_s);
    assign mem_we_s = access_s && acc_wr_s && !err_s && Rst_n;

    // Next-state logic for the IDLE/WAIT/RESP handshake sequence.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) state_nxt_s = ZERO_LAT ? ST_RESP : ST_WAIT;
                else          state_nxt_s = ST_IDLE;
            end
            ST_WAIT: begin
                if (cnt_r == 4'd0) state_nxt_s = ST_RESP;
                else               state_nxt_s = ST_WAIT;
            end
            ST_RESP: begin
                if (RspReady) state_nxt_s = ST_IDLE;
                else          state_nxt_s = ST_RESP;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Control state, request capture, latency counter and registered response.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= 4'd0;
            wr_r    <= 1'b0;
            addr_r  <= 32'd0;
            f3_r    <= 3'd0;
            wdata_r <= 32'd0;
            ready_r <= 1'b1;
            valid_r <= 1'b0;
            rdata_r <= 32'd0;
            err_r   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            ready_r <= (state_nxt_s == ST_IDLE);
            valid_r <= (state_nxt_s == ST_RESP);
            if (accept_s) begin
                cnt_r   <= CNT_INIT;
                wr_r    <= ReqWrite;
                addr_r  <= ReqAddr;
                f3_r    <= ReqFunct3;
                wdata_r <= ReqWData;
            end else if ((state_r == ST_WAIT) && (cnt_r != 4'd0)) begin
                cnt_r <= cnt_r - 4'd1;
            end
            if (access_s) begin
                rdata_r <= (acc_wr_s || err_s) ? 32'd0
                                               : load_extract(word_s, acc_addr_s[1:0], acc_f3_s);
                err_r   <= err_s;
            end
        end
    end

    // Memory array write port; contents are deliberately not reset.
    always_ff @(posedge Clk) begin
        if (mem_we_s) begin
            mem_r[idx_s] <= merged_s;
        end
    end

    assign ReqReady = ready_r;
    assign RspValid = valid_r;
    assign RspRData = rdata_r;
    assign RspErr   = err_r;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: a LATENCY=2 instance and a LATENCY=0
// instance, checked against a byte-addressed reference model.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req_valid = 2'b00;
    logic [1:0]  req_ready;
    logic        req_write = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_wdata = 32'd0;
    logic [1:0]  rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata [2];
    logic [1:0]  rsp_err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] rd;
        logic        er;
        int          d;
    } exp_t;
    exp_t exp_q[$];

    bit [7:0] mem_b [2][4096];

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) u_lat2 (
        .Clk(clk), .Rst_n(rst_n), .ReqValid(req_valid[0]), .ReqReady(req_ready[0]),
        .ReqWrite(req_write), .ReqAddr(req_addr), .ReqFunct3(req_funct3), .ReqWData(req_wdata),
        .RspValid(rsp_valid[0]), .RspReady(rsp_ready), .RspRData(rsp_rdata[0]), .RspErr(rsp_err[0])
    );

    dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(0)) u_lat0 (
        .Clk(clk), .Rst_n(rst_n), .ReqValid(req_valid[1]), .ReqReady(req_ready[1]),
        .ReqWrite(req_write), .ReqAddr(req_addr), .ReqFunct3(req_funct3), .ReqWData(req_wdata),
        .RspValid(rsp_valid[1]), .RspReady(rsp_ready), .RspRData(rsp_rdata[1]), .RspErr(rsp_err[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: memory as a flat byte array, access size from funct3.
    function automatic void model(input int d, input bit w, input logic [31:0] a,
                                  input logic [2:0] f3, input logic [31:0] wd,
                                  output logic [31:0] rd, output logic er);
        bit sup;
        bit uns;
        int sz;
        int ba;
        logic [31:0] v;
        sup = w ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        sz  = (!sup || f3[1:0] == 2'd2) ? 4 : ((f3[1:0] == 2'd1) ? 2 : 1);
        uns = sup && f3[2];
`ifdef DMEM_FAULT_CHECK_EN
        er = !sup || ((int'(a[1:0]) % sz) != 0) || (a[31:2] >= 30'd1024);
`else
        er = 1'b0;
`endif
        rd = 32'd0;
        if (er) return;
        ba = int'(a[31:2] % 30'd1024) * 4 + (int'(a[1:0]) / sz) * sz;
        v = 32'd0;
        for (int i = 0; i < sz; i++) begin
            if (w) mem_b[d][ba + i] = wd[8*i +: 8];
            else   v[8*i +: 8] = mem_b[d][ba + i];
        end
        if (!w) begin
            if (sz == 4 || uns) rd = v;
            else if (sz == 2)   rd = {{16{v[15]}}, v[15:0]};
            else                rd = {{24{v[7]}}, v[7:0]};
        end
    endfunction

    // Monitor: every response handshake pops and compares one expected entry.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (rst_n && rsp_valid[d] && rsp_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_rsp", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("rsp_dut", d, e.d);
                        chk("rsp_rdata", rsp_rdata[d], e.rd);
                        chk("rsp_err", {31'd0, rsp_err[d]}, {31'd0, e.er});
                    end
                end
            end
        end
    end

    // One complete transaction; called and returns at posedge+1.
    task automatic txn(input int d, input bit w, input logic [31:0] a, input logic [2:0] f3,
                       input logic [31:0] wd, input int hold);
        exp_t e;
        int n;
        int lat;
        lat = (d == 0) ? 2 : 0;
        model(d, w, a, f3, wd, e.rd, e.er);
        e.d = d;
        exp_q.push_back(e);
        req_write = w; req_addr = a; req_funct3 = f3; req_wdata = wd;
        req_valid[d] = 1'b1;
        n = 0;
        while (!req_ready[d] && n < 20) begin
            @(posedge clk); #1; n++;
        end
        chk("accept", {31'd0, req_ready[d]}, 32'd1);
        @(posedge clk); #1;
        req_valid[d] = 1'b0;
        req_addr = $urandom; req_wdata = $urandom; req_funct3 = 3'($urandom); req_write = 1'($urandom);
        n = 1;
        while (!rsp_valid[d] && n < 40) begin
            @(posedge clk); #1; n++;
        end
        chk("latency", n, lat + 1);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("hold_valid", {31'd0, rsp_valid[d]}, 32'd1);
            chk("hold_rdata", rsp_rdata[d], e.rd);
            chk("hold_ready", {31'd0, req_ready[d]}, 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk("rsp_drop", {31'd0, rsp_valid[d]}, 32'd0);
        chk("ready_back", {31'd0, req_ready[d]}, 32'd1);
    endtask

    task automatic rand_txns(input int d, input int cnt);
        logic [31:0] a;
        for (int i = 0; i < cnt; i++) begin
            a = 32'h100 + ($urandom % 64);
            if (($urandom % 8) == 0) a = a + 32'h1000;
            txn(d, 1'($urandom), a, 3'($urandom), $urandom, int'($urandom % 4));
        end
    endtask

    task automatic seed(input int d);
        for (int i = 0; i < 16; i++) txn(d, 1'b1, 32'h100 + 32'(4 * i), 3'b010, $urandom, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("rst_ready", {31'd0, req_ready[d]}, 32'd1);
            chk("rst_valid", {31'd0, rsp_valid[d]}, 32'd0);
            chk("rst_rdata", rsp_rdata[d], 32'd0);
            chk("rst_err", {31'd0, rsp_err[d]}, 32'd0);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Store interrupted by reset during WAIT must be dropped.
        txn(0, 1'b1, 32'h10, 3'b010, 32'h0, 0);
        req_write = 1'b1; req_addr = 32'h10; req_funct3 = 3'b010; req_wdata = 32'hDEADBEEF;
        req_valid[0] = 1'b1;
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", {31'd0, rsp_valid[0]}, 32'd0);
        @(posedge clk); #1;
        chk("midrst_valid2", {31'd0, rsp_valid[0]}, 32'd0);
        @(posedge clk); #1;
        chk("midrst_valid3", {31'd0, rsp_valid[0]}, 32'd0);
        rst_n = 1'b1;
        txn(0, 1'b0, 32'h10, 3'b010, 32'h0, 0);

        txn(0, 1'b1, 32'h20, 3'b010, 32'h800000F0, 0);
        txn(0, 1'b0, 32'h20, 3'b010, 32'h0, 0);
        txn(0, 1'b0, 32'h20, 3'b000, 32'h0, 1);
        txn(0, 1'b0, 32'h20, 3'b100, 32'h0, 0);
        txn(0, 1'b0, 32'h22, 3'b001, 32'h0, 2);
        txn(0, 1'b0, 32'h22, 3'b101, 32'h0, 0);
        txn(0, 1'b1, 32'h21, 3'b000, 32'hFFFFFFAB, 0);
        txn(0, 1'b0, 32'h20, 3'b010, 32'h0, 0);
        txn(0, 1'b1, 32'h22, 3'b001, 32'hCDEF1234, 0);
        txn(0, 1'b0, 32'h20, 3'b010, 32'h0, 0);
        txn(0, 1'b0, 32'h22, 3'b010, 32'h0, 0);
        txn(0, 1'b1, 32'h1000, 3'b010, 32'h55AA55AA, 0);
        txn(0, 1'b0, 32'h20, 3'b010, 32'h0, 5);

        seed(0);
        rand_txns(0, 60);

        seed(1);
        txn(1, 1'b1, 32'h20, 3'b010, 32'h800000F0, 0);
        txn(1, 1'b0, 32'h20, 3'b010, 32'h0, 5);
        txn(1, 1'b0, 32'h23, 3'b000, 32'h0, 0);
        rand_txns(1, 25);

        repeat (2) @(posedge clk);
        chk("queue_empty", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
